// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer: FSM states, pattern ids
// (which double as priorities) and the note/duration ROM.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] PAT_WALL   = 2'd0;
    localparam logic [1:0] PAT_PADDLE = 2'd1;
    localparam logic [1:0] PAT_GOAL   = 2'd2;

    localparam logic [3:0] GOAL_NOTE0 = 4'd0;
    localparam logic [3:0] GOAL_NOTE1 = 4'd4;
    localparam logic [3:0] GOAL_NOTE2 = 4'd7;
    localparam logic [3:0] GOAL_NOTE3 = 4'd12;
    localparam logic [3:0] PADDLE_NOTE = 4'd9;
    localparam logic [3:0] WALL_NOTE   = 4'd5;

    localparam logic [7:0] GOAL_DUR   = 8'd150;
    localparam logic [7:0] PADDLE_DUR = 8'd40;
    localparam logic [7:0] WALL_DUR   = 8'd25;

    localparam logic [1:0] GOAL_LAST_STEP = 2'd3;

    function automatic logic [3:0] pat_note(input logic [1:0] pat, input logic [1:0] step);
        logic [3:0] note;
        note = WALL_NOTE;
        if (pat == PAT_GOAL) begin
            case (step)
                2'd0:    note = GOAL_NOTE0;
                2'd1:    note = GOAL_NOTE1;
                2'd2:    note = GOAL_NOTE2;
                default: note = GOAL_NOTE3;
            endcase
        end else if (pat == PAT_PADDLE) begin
            note = PADDLE_NOTE;
        end
        return note;
    endfunction

    function automatic logic [7:0] pat_dur(input logic [1:0] pat);
        logic [7:0] dur;
        dur = WALL_DUR;
        if (pat == PAT_GOAL) dur = GOAL_DUR;
        else if (pat == PAT_PADDLE) dur = PADDLE_DUR;
        return dur;
    endfunction

    function automatic logic [1:0] pat_last_step(input logic [1:0] pat);
        return (pat == PAT_GOAL) ? GOAL_LAST_STEP : 2'd0;
    endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// Duration prescaler: emits a one-cycle tick every TICK_DIV cycles and
// restarts its count whenever a note or gap begins.
module sfx_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns single-cycle game events into timed note patterns for the tone
// generator, with fixed-priority preemption between overlapping events.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evt_goal,
    input  logic       evt_paddle,
    input  logic       evt_wall,
    output logic       tone_en,
    output logic [3:0] note_idx,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [1:0] pat_q, pat_d;
    logic [1:0] step_q, step_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic       tone_en_q, tone_en_d;
    logic [3:0] note_idx_q, note_idx_d;
    logic       busy_q, busy_d;

    logic       tick;
    logic       presc_clear;
    logic       evt_any;
    logic [1:0] evt_pat;
    logic       expired;
    logic       restart;

    sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    always_comb begin
        evt_any = evt_goal | evt_paddle | evt_wall;
        evt_pat = evt_goal ? PAT_GOAL : (evt_paddle ? PAT_PADDLE : PAT_WALL);
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        step_d      = step_q;
        tick_cnt_d  = tick_cnt_q;
        presc_clear = 1'b0;
        expired     = 1'b0;
        restart     = evt_any && ((state_q == IDLE) || (evt_pat >= pat_q));

        case (state_q)
            PLAY:    expired = tick && (tick_cnt_q == pat_dur(pat_q) - 8'd1);
            GAP:     expired = tick && (tick_cnt_q == 8'(GAP_TICKS - 1));
            default: expired = 1'b0;
        endcase

        // An accepted event wins even on the edge where the current pattern expires.
        if (restart) begin
            state_d     = PLAY;
            pat_d       = evt_pat;
            step_d      = 2'd0;
            tick_cnt_d  = 8'd0;
            presc_clear = 1'b1;
        end else if (state_q != IDLE) begin
            if (expired) begin
                tick_cnt_d = 8'd0;
                if (state_q == GAP) begin
                    state_d     = PLAY;
                    step_d      = step_q + 2'd1;
                    presc_clear = 1'b1;
                end else if (step_q == pat_last_step(pat_q)) begin
                    state_d = IDLE;
                end else begin
                    state_d     = GAP;
                    presc_clear = 1'b1;
                end
            end else if (tick) begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end
        end

        tone_en_d  = (state_d == PLAY);
        busy_d     = (state_d != IDLE);
        note_idx_d = note_idx_q;
        if (state_d == PLAY) note_idx_d = pat_note(pat_d, step_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pat_q      <= PAT_WALL;
            step_q     <= 2'd0;
            tick_cnt_q <= 8'd0;
            tone_en_q  <= 1'b0;
            note_idx_q <= 4'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            tone_en_q  <= tone_en_d;
            note_idx_q <= note_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign tone_en  = tone_en_q;
    assign note_idx = note_idx_q;
    assign busy     = busy_q;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer that sits directly upstream of the audio tone generator. It converts single-cycle game events (goal, paddle hit, wall hit) into timed note patterns. For each pattern it drives a tone enable and a 4-bit note index into the 16-entry frequency table used by the tone generator, and it arbitrates between overlapping events by fixed priority.

## Interface
Parameters:
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz). Legal values are ≥ 2. The bench uses 4.
- GAP_TICKS, 10: silent ticks between consecutive notes of a multi-note pattern.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- evt_goal  input  1  single-cycle pulse from scoring logic; priority 2 (highest).
- evt_paddle  input  1  single-cycle pulse from collision logic; priority 1.
- evt_wall  input  1  single-cycle pulse from collision logic; priority 0.
- tone_en  output  1  high while a note sounds; feeds the tone generator enable.
- note_idx  output  4  frequency-table index of the current note.
- busy  output  1  high from pattern start until the last note ends.

## Operation
- Patterns, as note index / duration in ticks:
  - goal: 0/150, 4/150, 7/150, 12/150, with GAP_TICKS between notes.
  - paddle: 9/40.
  - wall: 5/25.
- FSM states:
  - IDLE: tone_en=0, busy=0.
  - PLAY: tone_en=1, note_idx = current step.
  - GAP: tone_en=0, busy=1, note_idx holds the last note.
- Transitions:
  - IDLE→PLAY on any event.
  - PLAY→GAP when the note duration expires and more steps remain.
  - PLAY→IDLE when the duration expires on the last step.
  - GAP→PLAY when GAP_TICKS expire; the step increments.
- Arbitration:
  - Simultaneous events in one cycle: the highest priority wins and the others are dropped.
  - While busy, an event of priority ≥ the active pattern's priority restarts at step 0 of the new pattern. An event of lower priority is dropped.
  - This applies in both PLAY and GAP.
- Duration counting:
  - A prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick.
  - The prescaler is cleared whenever a note or gap starts, so every note lasts exactly duration×TICK_DIV cycles.
  - The tick counter is 8 bits and counts ticks up to duration-1, then expires.
  - The step counter is 2 bits and never wraps past the pattern length.
- Events are not queued; a dropped event is lost.

## Timing
- Reset values: tone_en=0, note_idx=0, busy=0, state IDLE, all counters 0.
- Reset acts immediately, asynchronously, including mid-pattern. After release the block stays in IDLE; nothing resumes.
- Event sampled at rising edge N → tone_en, note_idx and busy valid after edge N+1 (1-cycle latency).
- Note expiry: tone_en falls on the edge where the final tick of that note is counted. busy falls on the same edge for the last note.
- An event arriving on the same edge as pattern expiry is treated as an event while busy, using the priority rule against the expiring pattern.
- If that event is dropped, the block returns to IDLE.
- Outputs are registered and glitch-free; no combinational path runs from the event inputs to the outputs.

## Structure
- Package sfx_pkg holds:
  - the state encoding (IDLE, PLAY, GAP);
  - pattern id constants (PAT_WALL=0, PAT_PADDLE=1, PAT_GOAL=2), where the id doubles as the priority;
  - the pattern ROM constants: note index, duration, pattern length.
- Sub-module sfx_tick_gen: the prescaler, with synchronous clear input and one-cycle tick output, parameterised by TICK_DIV.
- Everything else lives in sfx_sequencer: FSM, step/tick counters, arbitration.

## Test plan
All scenarios use TICK_DIV=4 and GAP_TICKS=10.
- Reset asserted, then released, with no events → tone_en=0, note_idx=0, busy=0 for 1000 cycles.
- evt_wall pulse at edge N → from N+1: tone_en=1, note_idx=5 for exactly 100 cycles, then tone_en=0 and busy=0.
- evt_goal pulse → note 0, 4, 7, 12, each for 600 cycles, with 40-cycle silent gaps; busy high for 2520 cycles total.
- Preemption and drop:
  - During the goal pattern (note 4), evt_paddle → ignored, and the goal pattern completes unchanged.
  - During the paddle pattern, evt_goal → note_idx=0 the next cycle, and the full goal pattern follows.
- evt_wall and evt_paddle in the same cycle → note 9 for 160 cycles; note 5 never appears.
- Reset asserted mid-way through goal note 7 → tone_en=0 and busy=0 before the next clock edge. After release the block stays IDLE until a new event arrives.
